// File: rtl/text_mode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : text_mode_pkg
// Description : Shared definitions for the UART-driven text-mode writer:
//               ASCII control codes, default screen geometry, writer state
//               encoding, cursor-step operations and a printable-byte test.
//               The CLEAR state exists only when UART_TEXT_CLEAR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package text_mode_pkg;

    localparam int DEFAULT_COLS = 80;
    localparam int DEFAULT_ROWS = 30;

    localparam logic [7:0] ASCII_BS       = 8'h08;
    localparam logic [7:0] ASCII_LF       = 8'h0A;
    localparam logic [7:0] ASCII_FF       = 8'h0C;
    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [6:0] ASCII_SPACE    = 7'h20;
    localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
    localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_EXEC  = 2'd1;
    localparam logic [ST_W-1:0] ST_ERASE = 2'd2;
    localparam logic [ST_W-1:0] ST_CLEAR = 2'd3;

    typedef enum logic [ST_W-1:0] {
        S_IDLE  = ST_IDLE,
        S_EXEC  = ST_EXEC,
        S_ERASE = ST_ERASE
`ifdef UART_TEXT_CLEAR_EN
        ,
        S_CLEAR = ST_CLEAR
`endif
    } state_t;

    // Cursor movements supported by cursor_step.
    typedef enum logic [2:0] {
        CUR_HOLD    = 3'd0,
        CUR_ADVANCE = 3'd1,
        CUR_CR      = 3'd2,
        CUR_LF      = 3'd3,
        CUR_BACK    = 3'd4,
        CUR_HOME    = 3'd5
    } cursor_op_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= ASCII_PRINT_LO) && (b <= ASCII_PRINT_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cursor_step.sv
`default_nettype none
// ============================================================================
// Module      : cursor_step
// Description : Purely combinational next-cursor calculation. Given a cursor
//               (x,y) and an operation it returns the moved cursor, keeping
//               x in 0..COLS-1 and y in 0..ROWS-1 (row and screen wrap, no
//               scrolling).
// Ports       : i_x, i_y      current column / row
//               i_op          cursor_op_t movement
//               o_next_x/y    resulting column / row
// Revision    : 1.0 - initial release
// ============================================================================
module cursor_step
    import text_mode_pkg::*;
#(
    parameter int COLS = DEFAULT_COLS,
    parameter int ROWS = DEFAULT_ROWS,
    parameter int X_W  = 7,
    parameter int Y_W  = 5
) (
    input  logic [X_W-1:0] i_x,
    input  logic [Y_W-1:0] i_y,
    input  cursor_op_t     i_op,
    output logic [X_W-1:0] o_next_x,
    output logic [Y_W-1:0] o_next_y
);

    localparam logic [X_W-1:0] C_X_MAX = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] C_Y_MAX = Y_W'(ROWS - 1);

    logic [Y_W-1:0] w_y_down;

    // Row below the current one, wrapping the bottom row back to the top.
    assign w_y_down = (i_y == C_Y_MAX) ? '0 : i_y + 1'b1;

    always_comb begin
        o_next_x = i_x;
        o_next_y = i_y;
        case (i_op)
            CUR_ADVANCE: begin
                if (i_x == C_X_MAX) begin
                    o_next_x = '0;
                    o_next_y = w_y_down;
                end else begin
                    o_next_x = i_x + 1'b1;
                end
            end
            CUR_CR: o_next_x = '0;
            CUR_LF: o_next_y = w_y_down;
            CUR_BACK: begin
                // Backing up from the home position leaves the cursor there.
                if (i_x != '0) begin
                    o_next_x = i_x - 1'b1;
                end else if (i_y != '0) begin
                    o_next_x = C_X_MAX;
                    o_next_y = i_y - 1'b1;
                end
            end
            CUR_HOME: begin
                o_next_x = '0;
                o_next_y = '0;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/uart_text_writer.sv
`default_nettype none
// ============================================================================
// Module      : uart_text_writer
// Description : Terminal-style writer between the UART RX FIFO and the
//               text-mode tile RAM write port. Pops bytes, writes printable
//               ASCII at the cursor and interprets CR, LF, BS (and FF when
//               enabled). The cursor is exported for underline rendering.
// Build macro : UART_TEXT_CLEAR_EN - when defined, FF sweeps the whole screen
//               with spaces and homes the cursor; otherwise FF is ignored.
// Ports       : clk, rst_n          clock, async active-low reset
//               rx_empty, rx_data   RX FIFO flag and head byte
//               rd_uart             one-cycle FIFO pop strobe
//               wr_en/addr/data     tile RAM write port, addr = {y,x}
//               cursor_x/y          registered cursor position
//               busy                high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module uart_text_writer
    import text_mode_pkg::*;
#(
    parameter int COLS   = DEFAULT_COLS,
    parameter int ROWS   = DEFAULT_ROWS,
    parameter int X_W    = 7,
    parameter int Y_W    = 5,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_empty,
    input  logic [7:0]        rx_data,
    output logic              rd_uart,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [X_W-1:0]    cursor_x,
    output logic [Y_W-1:0]    cursor_y,
    output logic              busy
);

    state_t            r_state;
    logic [7:0]        r_byte;
    logic              r_run;
    logic [X_W-1:0]    r_cx;
    logic [Y_W-1:0]    r_cy;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_busy;

    cursor_op_t        w_op;
    logic [X_W-1:0]    w_nx;
    logic [Y_W-1:0]    w_ny;
    logic              w_pop;

    // r_run holds off the pop strobe while reset is asserted, so every
    // output is low during reset even if the FIFO is not empty.
    assign w_pop = r_run && (r_state == S_IDLE) && !rx_empty;

`ifdef UART_TEXT_CLEAR_EN
    localparam logic [X_W-1:0] C_X_MAX = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] C_Y_MAX = Y_W'(ROWS - 1);

    // Sweep position currently presented on the write port during CLEAR.
    logic [X_W-1:0] r_clr_x;
    logic [Y_W-1:0] r_clr_y;
    logic [X_W-1:0] w_clr_nx;
    logic [Y_W-1:0] w_clr_ny;
    logic           w_clr_last;

    assign w_clr_last = (r_clr_x == C_X_MAX) && (r_clr_y == C_Y_MAX);

    cursor_step #(
        .COLS (COLS),
        .ROWS (ROWS),
        .X_W  (X_W),
        .Y_W  (Y_W)
    ) u_sweep_step (
        .i_x      (r_clr_x),
        .i_y      (r_clr_y),
        .i_op     (CUR_ADVANCE),
        .o_next_x (w_clr_nx),
        .o_next_y (w_clr_ny)
    );
`endif

    // Cursor movement is applied in EXEC (one cycle after the pop), which
    // makes the new position visible two cycles after the pop strobe.
    always_comb begin
        w_op = CUR_HOLD;
        if (r_state == S_EXEC) begin
            if (is_printable(r_byte)) begin
                w_op = CUR_ADVANCE;
            end else if (r_byte == ASCII_CR) begin
                w_op = CUR_CR;
            end else if (r_byte == ASCII_LF) begin
                w_op = CUR_LF;
            end else if (r_byte == ASCII_BS) begin
                w_op = CUR_BACK;
            end
        end
`ifdef UART_TEXT_CLEAR_EN
        else if ((r_state == S_CLEAR) && w_clr_last) begin
            w_op = CUR_HOME;
        end
`endif
    end

    cursor_step #(
        .COLS (COLS),
        .ROWS (ROWS),
        .X_W  (X_W),
        .Y_W  (Y_W)
    ) u_cursor_step (
        .i_x      (r_cx),
        .i_y      (r_cy),
        .i_op     (w_op),
        .o_next_x (w_nx),
        .o_next_y (w_ny)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_byte    <= '0;
            r_run     <= 1'b0;
            r_cx      <= '0;
            r_cy      <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
`ifdef UART_TEXT_CLEAR_EN
            r_clr_x   <= '0;
            r_clr_y   <= '0;
`endif
        end else begin
            r_run   <= 1'b1;
            r_wr_en <= 1'b0;
            r_cx    <= w_nx;
            r_cy    <= w_ny;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_byte  <= rx_data;
                        r_state <= S_EXEC;
                        r_busy  <= 1'b1;
                        // The character write is registered here so it lands
                        // in the EXEC cycle at the pre-advance cursor.
                        if (is_printable(rx_data)) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= {r_cy, r_cx};
                            r_wr_data <= rx_data[DATA_W-1:0];
                        end
                    end
                end
                S_EXEC: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (r_byte == ASCII_BS) begin
                        // Erase at the backed-up position during ERASE.
                        r_state   <= S_ERASE;
                        r_busy    <= 1'b1;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= {w_ny, w_nx};
                        r_wr_data <= ASCII_SPACE;
                    end
`ifdef UART_TEXT_CLEAR_EN
                    else if (r_byte == ASCII_FF) begin
                        r_state   <= S_CLEAR;
                        r_busy    <= 1'b1;
                        r_clr_x   <= '0;
                        r_clr_y   <= '0;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= '0;
                        r_wr_data <= ASCII_SPACE;
                    end
`endif
                end
                S_ERASE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
`ifdef UART_TEXT_CLEAR_EN
                S_CLEAR: begin
                    if (w_clr_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_clr_x   <= w_clr_nx;
                        r_clr_y   <= w_clr_ny;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= {w_clr_ny, w_clr_nx};
                        r_wr_data <= ASCII_SPACE;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_uart  = w_pop;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign cursor_x = r_cx;
    assign cursor_y = r_cy;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_text_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_text_writer
// Description : Self-checking bench for uart_text_writer. A queue models the
//               RX FIFO; a screen-position reference model predicts tile
//               writes and the final cursor for each byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_text_writer;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int X_W    = 7;
    localparam int Y_W    = 5;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_empty = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rd_uart;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [X_W-1:0]    cursor_x;
    logic [Y_W-1:0]    cursor_y;
    logic              busy;

    uart_text_writer #(
        .COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_empty(rx_empty), .rx_data(rx_data),
        .rd_uart(rd_uart), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int d; } wr_t;

    logic [7:0] fifo[$];
    bit         pop_pend;
    int         pop_cyc[$];
    wr_t        obs[$];
    wr_t        expw[$];
    int         cyc;
    int         busy_cycles;
    int         empty_pops;
    int         m_x, m_y;
    int         checks;
    int         failures;

    // FIFO model and monitor. Inputs change at the falling edge; a pop seen
    // mid-cycle is taken off the queue only after the consuming rising edge.
    always @(negedge clk) begin
        wr_t w;
        cyc++;
        if (pop_pend) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            pop_pend = 1'b0;
        end
        rx_empty = (fifo.size() == 0);
        rx_data  = rx_empty ? 8'h00 : fifo[0];
        #1;
        if (rd_uart) begin
            if (rx_empty) empty_pops++;
            else pop_pend = 1'b1;
            pop_cyc.push_back(cyc);
        end
        if (wr_en) begin
            w.x = int'(wr_addr[X_W-1:0]);
            w.y = int'(wr_addr[ADDR_W-1:X_W]);
            w.d = int'(wr_data);
            obs.push_back(w);
        end
        if (busy) busy_cycles++;
    end

    // Reference model: cursor as a linear screen position.
    task automatic model_byte(input logic [7:0] b);
        int  pos;
        wr_t w;
        pos = m_y * COLS + m_x;
        if (b >= 8'h20 && b <= 8'h7E) begin
            w.x = m_x; w.y = m_y; w.d = int'(b[6:0]);
            expw.push_back(w);
            pos = (pos + 1) % (COLS * ROWS);
        end else if (b == 8'h0D) begin
            pos = m_y * COLS;
        end else if (b == 8'h0A) begin
            pos = ((m_y + 1) % ROWS) * COLS + m_x;
        end else if (b == 8'h08) begin
            if (pos > 0) pos = pos - 1;
            w.x = pos % COLS; w.y = pos / COLS; w.d = 32;
            expw.push_back(w);
        end
`ifdef UART_TEXT_CLEAR_EN
        else if (b == 8'h0C) begin
            for (int i = 0; i < COLS * ROWS; i++) begin
                w.x = i % COLS; w.y = i / COLS; w.d = 32;
                expw.push_back(w);
            end
            pos = 0;
        end
`endif
        m_x = pos % COLS;
        m_y = pos / COLS;
    endtask

    task automatic send(input logic [7:0] b);
        fifo.push_back(b);
        model_byte(b);
    endtask

    task automatic clear_logs();
        obs.delete();
        expw.delete();
        pop_cyc.delete();
        busy_cycles = 0;
        empty_pops  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        fifo.delete();
        pop_pend = 1'b0;
        m_x = 0;
        m_y = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        clear_logs();
    endtask

    // Waits until every queued byte is consumed and the writer is idle.
    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk); #2;
            if (fifo.size() == 0 && !pop_pend && !busy && rx_empty) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int writes_diff();
        int n;
        n = (obs.size() < expw.size()) ? obs.size() : expw.size();
        for (int i = 0; i < n; i++)
            if (obs[i].x != expw[i].x || obs[i].y != expw[i].y || obs[i].d != expw[i].d) return i;
        if (obs.size() != expw.size()) return n;
        return -1;
    endfunction

    function automatic string wr_str(input bit from_exp, input int i);
        if (!from_exp && i < obs.size())
            return $sformatf("(x=%0d,y=%0d,d=0x%02h)", obs[i].x, obs[i].y, obs[i].d);
        if (from_exp && i < expw.size())
            return $sformatf("(x=%0d,y=%0d,d=0x%02h)", expw[i].x, expw[i].y, expw[i].d);
        return "none";
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b required 0", wr_en); end
        checks++; if (rd_uart !== 1'b0) begin failures++; $display("FAIL reset_rd_uart: got %b required 0", rd_uart); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (wr_addr !== '0) begin failures++; $display("FAIL reset_wr_addr: got %h required 0", wr_addr); end
        checks++; if (wr_data !== '0) begin failures++; $display("FAIL reset_wr_data: got %h required 0", wr_data); end
        checks++; if (cursor_x !== '0 || cursor_y !== '0) begin failures++; $display("FAIL reset_cursor: got (%0d,%0d) required (0,0)", cursor_x, cursor_y); end
        do_reset();
    endtask

    task automatic test_first_char();
        bit ok;
        int d;
        do_reset();
        send(8'h41);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); #2;
            if (rd_uart) break;
        end
        checks++; if (rd_uart !== 1'b1) begin failures++; $display("FAIL first_pop: rd_uart got %b required 1", rd_uart); end
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL first_no_early_write: wr_en got %b required 0", wr_en); end
        @(negedge clk); #2;
        checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL first_wr_en: got %b required 1", wr_en); end
        checks++; if (wr_addr !== 12'h000) begin failures++; $display("FAIL first_wr_addr: got %h required 000", wr_addr); end
        checks++; if (wr_data !== 7'h41) begin failures++; $display("FAIL first_wr_data: got %h required 41", wr_data); end
        checks++; if (cursor_x !== 7'd0) begin failures++; $display("FAIL first_cursor_hold: got %0d required 0", cursor_x); end
        checks++; if (rd_uart !== 1'b0) begin failures++; $display("FAIL first_single_pop: rd_uart got %b required 0", rd_uart); end
        @(negedge clk); #2;
        checks++; if (cursor_x !== 7'd1 || cursor_y !== 5'd0) begin failures++; $display("FAIL first_cursor: got (%0d,%0d) required (1,0)", cursor_x, cursor_y); end
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL first_single_write: wr_en got %b required 0", wr_en); end
        drain(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL first_drain: timed out, got %b required 1", ok); end
        d = writes_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL first_writes: entry %0d got %s required %s", d, wr_str(0, d), wr_str(1, d)); end
    endtask

    task automatic test_wrap();
        bit ok;
        int d;
        do_reset();
        for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
        for (int i = 0; i < COLS - 1; i++) send(8'($urandom_range(8'h21, 8'h7E)));
        drain(ok);
        checks++; if (int'(cursor_x) !== 79 || int'(cursor_y) !== 29) begin failures++; $display("FAIL wrap_setup_cursor: got (%0d,%0d) required (79,29)", cursor_x, cursor_y); end
        d = writes_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL wrap_setup_writes: entry %0d got %s required %s", d, wr_str(0, d), wr_str(1, d)); end
        clear_logs();
        send(8'h5A);
        drain(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wrap_drain: timed out, got %b required 1", ok); end
        d = writes_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL wrap_writes: entry %0d got %s (of %0d) required %s (of %0d)", d, wr_str(0, d), obs.size(), wr_str(1, d), expw.size()); end
        checks++; if (int'(cursor_x) !== m_x || int'(cursor_y) !== m_y) begin failures++; $display("FAIL wrap_cursor: got (%0d,%0d) required (%0d,%0d)", cursor_x, cursor_y, m_x, m_y); end
    endtask

    task automatic test_backspace();
        bit ok;
        int d;
        do_reset();
        for (int i = 0; i < 5; i++) send(8'h0A);
        drain(ok);
        clear_logs();
        send(8'h08);
        drain(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bs_drain: timed out, got %b required 1", ok); end
        d = writes_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL bs_row_writes: entry %0d got %s required %s", d, wr_str(0, d), wr_str(1, d)); end
        checks++; if (int'(cursor_x) !== 79 || int'(cursor_y) !== 4) begin failures++; $display("FAIL bs_row_cursor: got (%0d,%0d) required (79,4)", cursor_x, cursor_y); end
        checks++; if (busy_cycles !== 2) begin failures++; $display("FAIL bs_busy_cycles: got %0d required 2", busy_cycles); end
        do_reset();
        send(8'h08);
        drain(ok);
        d = writes_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL bs_home_writes: entry %0d got %s required %s", d, wr_str(0, d), wr_str(1, d)); end
        checks++; if (cursor_x !== '0 || cursor_y !== '0) begin failures++; $display("FAIL bs_home_cursor: got (%0d,%0d) required (0,0)", cursor_x, cursor_y); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d;
        logic [7:0] msg [5];
        msg = '{8'h41, 8'h42, 8'h0D, 8'h0A, 8'h43};
        do_reset();
        foreach (msg[i]) send(msg[i]);
        drain(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL b2b_drain: timed out, got %b required 1", ok); end
        d = writes_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL b2b_writes: entry %0d got %s (of %0d) required %s (of %0d)", d, wr_str(0, d), obs.size(), wr_str(1, d), expw.size()); end
        checks++; if (int'(cursor_x) !== 1 || int'(cursor_y) !== 1) begin failures++; $display("FAIL b2b_cursor: got (%0d,%0d) required (1,1)", cursor_x, cursor_y); end
        checks++; if (pop_cyc.size() !== 5) begin failures++; $display("FAIL b2b_pop_count: got %0d required 5", pop_cyc.size()); end
        for (int i = 1; i < pop_cyc.size(); i++) begin
            checks++;
            if (pop_cyc[i] - pop_cyc[i-1] !== 2) begin failures++; $display("FAIL b2b_pop_spacing: pop %0d gap got %0d required 2", i, pop_cyc[i] - pop_cyc[i-1]); end
        end
        checks++; if (empty_pops !== 0) begin failures++; $display("FAIL b2b_pop_when_empty: got %0d required 0", empty_pops); end
    endtask

    task automatic test_ignored();
        bit ok;
        int n;
        do_reset();
        send(8'h71);
        send(8'h72);
        drain(ok);
        clear_logs();
        send(8'h07); send(8'h7F); send(8'hC1);
        n = 3;
`ifndef UART_TEXT_CLEAR_EN
        send(8'h0C);
        n = 4;
`endif
        drain(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ign_drain: timed out, got %b required 1", ok); end
        checks++; if (pop_cyc.size() !== n) begin failures++; $display("FAIL ign_pops: got %0d required %0d", pop_cyc.size(), n); end
        checks++; if (obs.size() !== 0) begin failures++; $display("FAIL ign_writes: got %0d required 0", obs.size()); end
        checks++; if (int'(cursor_x) !== 2 || int'(cursor_y) !== 0) begin failures++; $display("FAIL ign_cursor: got (%0d,%0d) required (2,0)", cursor_x, cursor_y); end
    endtask

    task automatic test_random();
        bit ok;
        int d;
        int sel;
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)       b = 8'($urandom_range(8'h20, 8'h7E));
            else if (sel == 6) b = 8'h0D;
            else if (sel == 7) b = 8'h0A;
            else if (sel == 8) b = 8'h08;
            else begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h0C) b = 8'h0B;
            end
            send(b);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rand_drain: timed out, got %b required 1", ok); end
        d = writes_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL rand_writes: entry %0d got %s (of %0d) required %s (of %0d)", d, wr_str(0, d), obs.size(), wr_str(1, d), expw.size()); end
        checks++; if (int'(cursor_x) !== m_x || int'(cursor_y) !== m_y) begin failures++; $display("FAIL rand_cursor: got (%0d,%0d) required (%0d,%0d)", cursor_x, cursor_y, m_x, m_y); end
        checks++; if (pop_cyc.size() !== 120) begin failures++; $display("FAIL rand_pops: got %0d required 120", pop_cyc.size()); end
        checks++; if (empty_pops !== 0) begin failures++; $display("FAIL rand_pop_when_empty: got %0d required 0", empty_pops); end
    endtask

`ifdef UART_TEXT_CLEAR_EN
    task automatic test_clear();
        bit ok;
        int d;
        do_reset();
        send(8'h68); send(8'h0A); send(8'h69);
        drain(ok);
        clear_logs();
        send(8'h0C);
        drain(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL clr_drain: timed out, got %b required 1", ok); end
        checks++; if (obs.size() !== 2400) begin failures++; $display("FAIL clr_count: got %0d required 2400", obs.size()); end
        d = writes_diff();
        checks++; if (d != -1) begin failures++; $display("FAIL clr_writes: entry %0d got %s required %s", d, wr_str(0, d), wr_str(1, d)); end
        checks++; if (busy_cycles < 2400) begin failures++; $display("FAIL clr_busy: got %0d cycles required >= 2400", busy_cycles); end
        checks++; if (cursor_x !== '0 || cursor_y !== '0) begin failures++; $display("FAIL clr_cursor: got (%0d,%0d) required (0,0)", cursor_x, cursor_y); end

        // Reset in the middle of a sweep.
        send(8'h68);
        drain(ok);
        clear_logs();
        send(8'h0C);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); #2;
            if (obs.size() >= 1000) break;
        end
        checks++; if (obs.size() !== 1000) begin failures++; $display("FAIL clr_mid_reach: got %0d writes required 1000", obs.size()); end
        rst_n = 1'b0;
        #1;
        checks++; if (wr_en !== 1'b0 || busy !== 1'b0 || rd_uart !== 1'b0) begin failures++; $display("FAIL clr_mid_ctrl: wr_en/busy/rd_uart got %b%b%b required 000", wr_en, busy, rd_uart); end
        checks++; if (wr_addr !== '0 || wr_data !== '0) begin failures++; $display("FAIL clr_mid_port: addr/data got %h/%h required 0/0", wr_addr, wr_data); end
        checks++; if (cursor_x !== '0 || cursor_y !== '0) begin failures++; $display("FAIL clr_mid_cursor: got (%0d,%0d) required (0,0)", cursor_x, cursor_y); end
        fifo.delete();
        pop_pend = 1'b0;
        m_x = 0;
        m_y = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        clear_logs();
        repeat (10) @(negedge clk);
        #2;
        checks++; if (obs.size() !== 0 || busy !== 1'b0) begin failures++; $display("FAIL clr_no_resume: writes %0d busy %b required 0 and 0", obs.size(), busy); end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        m_x      = 0;
        m_y      = 0;
        test_reset();
        test_first_char();
        test_wrap();
        test_backspace();
        test_back_to_back();
        test_ignored();
        test_random();
`ifdef UART_TEXT_CLEAR_EN
        test_clear();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
